// File: rtl/timer_arbiter_if.sv
// Bundle between the round-robin timer arbiter, its requesters and the shared timer.
// slave = arbiter side, master = clients plus timer side.
interface timer_arbiter_if #(
    parameter int bits    = 15,
    parameter int num_req = 4
);
    logic [num_req-1:0]      req;
    logic [num_req*bits-1:0] delay;
    logic [num_req-1:0]      gnt;
    logic [num_req-1:0]      ack;
    logic                    busy;
    logic                    tmr_enable;
    logic [bits-1:0]         tmr_final_value;
    logic                    tmr_done;

    modport slave (
        input  req, delay, tmr_done,
        output gnt, ack, busy, tmr_enable, tmr_final_value
    );

    modport master (
        output req, delay, tmr_done,
        input  gnt, ack, busy, tmr_enable, tmr_final_value
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin scheduler sharing one timer between num_req requesters:
// latch winner's delay, run the timer until done, then pulse ack to the winner.
module timer_arbiter #(
    parameter int bits    = 15,
    parameter int num_req = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_arbiter_if.slave  bus
);
    localparam int PW = (num_req > 1) ? $clog2(num_req) : 1;
    localparam logic [PW:0] NR = (PW+1)'(num_req);

    typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

    state_t             state;
    logic [num_req-1:0] gnt_q;
    logic [bits-1:0]    fv_q;
    logic [PW-1:0]      ptr;

    logic [bits-1:0]      dly [num_req];
    logic [2*num_req-1:0] req2;
    logic [num_req-1:0]   rot;
    logic                 win_found;
    logic [PW-1:0]        win_off;
    logic [PW:0]          win_sum;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        ptr_next;
    logic [num_req-1:0]   win_onehot;

    for (genvar g = 0; g < num_req; g++) begin : g_dly
        assign dly[g] = bus.delay[g*bits +: bits];
    end

    // Rotate requests so bit 0 is the pointer's requester; first set bit wins.
    assign req2 = {bus.req, bus.req};
    assign rot  = num_req'(req2 >> ptr);

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int k = num_req-1; k >= 0; k--) begin
            if (rot[k]) begin
                win_found = 1'b1;
                win_off   = PW'(k);
            end
        end
    end

    assign win_sum    = {1'b0, ptr} + {1'b0, win_off};
    assign win_idx    = (win_sum >= NR) ? PW'(win_sum - NR) : PW'(win_sum);
    assign ptr_next   = (win_idx == PW'(num_req-1)) ? '0 : win_idx + 1'b1;
    assign win_onehot = {{(num_req-1){1'b0}}, 1'b1} << win_idx;

    // tmr_done is ignored outside RUN: an idle timer at count 0 may report done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt_q <= '0;
            fv_q  <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt_q <= win_onehot;
                        fv_q  <= dly[win_idx];
                        ptr   <= ptr_next;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.tmr_done) state <= ACK;
                end
                ACK: begin
                    gnt_q <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.ack             = (state == ACK) ? gnt_q : '0;
    assign bus.busy            = (state != IDLE);
    assign bus.tmr_enable      = (state == RUN);
    assign bus.tmr_final_value = fv_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_idle_no_gnt: assert property (@(posedge clk) disable iff (!rst_n)
                                    (state == IDLE) |-> (gnt_q == '0));
endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized scoreboard bench for timer_arbiter with a behavioural shared timer
// and a cycle-arithmetic reference model of the round-robin service order.
module tb_timer_arbiter;
    localparam int BITS = 15;
    localparam int N    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_arbiter_if #(.bits(BITS), .num_req(N)) bus ();
    timer_arbiter #(.bits(BITS), .num_req(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Shared timer: counts 0..final_value while enabled, done is combinational.
    logic [BITS-1:0] tcount;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcount <= '0;
        else if (bus.tmr_enable)
            tcount <= (tcount == bus.tmr_final_value) ? '0 : tcount + 1'b1;
    end
    assign bus.tmr_done = (tcount == bus.tmr_final_value);

    typedef struct {
        int w;
        int ack_cyc;
        int f;
    } exp_t;

    exp_t expq[$];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ptr_m  = 0;
    int s_w    = -1;
    int s_start = 0;
    int s_end  = -1;
    int s_f    = 0;
    bit keep_all = 1'b0;
    bit rnd_on   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Reference model: a grant decided in idle cycle c is acked in c+F+2,
    // and the next decision can happen in c+F+3.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ptr_m = 0;
            s_w   = -1;
            s_end = -1;
            expq.delete();
        end else begin
            if (cyc > s_end && bus.req != '0) begin
                exp_t e;
                e.w       = rr_pick(bus.req, ptr_m);
                e.f       = int'(bus.delay[e.w*BITS +: BITS]);
                e.ack_cyc = cyc + e.f + 2;
                s_w       = e.w;
                s_f       = e.f;
                s_start   = cyc + 1;
                s_end     = e.ack_cyc;
                ptr_m     = (e.w + 1) % N;
                expq.push_back(e);
            end
            cyc++;
        end
    end

    // Monitor: per-cycle output checks, ack pops the scoreboard.
    logic         in_svc;
    logic [N-1:0] eg;
    initial forever begin
        @(negedge clk);
        in_svc = (s_w >= 0) && (cyc >= s_start) && (cyc <= s_end);
        eg     = in_svc ? (N'(1) << s_w) : '0;
        chk("gnt", int'(bus.gnt), int'(eg));
        chk("busy", int'(bus.busy), int'(in_svc));
        chk("tmr_enable", int'(bus.tmr_enable), int'(in_svc && cyc < s_end));
        chk("ack_level", int'(bus.ack), (in_svc && cyc == s_end) ? int'(eg) : 0);
        if (in_svc) chk("final_value", int'(bus.tmr_final_value), s_f);
        if (bus.ack != '0) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack cyc=%0d actual=%0h expected=none", cyc, bus.ack);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("ack_who", int'(bus.ack), 1 << e.w);
                chk("ack_cycle", cyc, e.ack_cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (bus.ack[i] && !(keep_all || (rnd_on && $urandom_range(0, 3) == 0)))
                bus.req[i] = 1'b0;
            if (rnd_on) begin
                if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
                    bus.delay[i*BITS +: BITS] = BITS'($urandom_range(0, 12));
                    bus.req[i] = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.delay[i*BITS +: BITS] = BITS'($urandom_range(0, 12));
                end
            end
        end
    endtask

    task automatic issue(input int i, input int d);
        bus.delay[i*BITS +: BITS] = BITS'(d);
        bus.req[i] = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        keep_all = 1'b0;
        rnd_on   = 1'b0;
        while ((bus.req != '0 || bus.busy) && n < bound) begin
            step();
            n++;
        end
        chk("drain_done", int'(bus.req == '0 && !bus.busy), 1);
    endtask

    task automatic chk_reset();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_enable", int'(bus.tmr_enable), 0);
        chk("rst_final_value", int'(bus.tmr_final_value), 0);
    endtask

    initial begin
        int n;
        bus.req   = '0;
        bus.delay = '0;
        #12;
        chk_reset();
        step();
        step();
        rst_n = 1'b1;
        step();

        // single request, F=5
        issue(1, 5);
        drain(30);
        repeat (3) step();

        // simultaneous 0 and 2
        issue(0, 3);
        issue(2, 2);
        drain(40);

        // all four held continuously
        keep_all = 1'b1;
        issue(0, 1); issue(1, 2); issue(2, 3); issue(3, 0);
        repeat (60) step();
        drain(100);

        // F=0, then idle with done high and no request
        issue(3, 0);
        drain(20);
        repeat (5) step();

        // delay change during service
        issue(2, 10);
        repeat (4) step();
        bus.delay[2*BITS +: BITS] = BITS'(2);
        drain(40);

        // reset mid-RUN at count 4
        issue(0, 8);
        n = 0;
        while (!(bus.busy && tcount == BITS'(4)) && n < 30) begin
            step();
            n++;
        end
        chk("reached_count4", int'(tcount), 4);
        #2;
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        chk_reset();
        chk("timer_reset", int'(tcount), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        issue(1, 1);
        drain(20);

        // full-scale delay
        issue(2, (1 << BITS) - 1);
        drain(33000);

        // randomized traffic
        rnd_on = 1'b1;
        repeat (2000) step();
        drain(500);
        repeat (2) step();
        chk("queue_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
